bkm_control_seq: RTL and testbench
==================================

BKM_CONTROL_SEQ -- requirements
Module: bkm_control_seq

Interface
REQ-001 SHALL have parameter W, default 8: digit count of the u/v operands; each operand is CSD-encoded on 2*W bits.
REQ-002 SHALL have parameter N, default 8: iteration count per run, with 2 <= N <= 2**LOG2N.
REQ-003 SHALL have parameter LOG2W, default 3: log2 of W.
REQ-004 SHALL have parameter LOG2N, default 3: iteration counter width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port arst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port srst, input, 1 bit: synchronous active-high reset, qualified by enable.
REQ-008 SHALL have port enable, input, 1 bit: clock enable; when low, all state holds.
REQ-009 SHALL have port start, input, 1 bit: run request.
REQ-010 SHALL have ports mode (1 bit), format (2 bits), u_0 (2*W bits) and v_0 (2*W bits), all inputs: run operands, captured at start.
REQ-011 SHALL have ports lut_u and lut_v, inputs, 2*W bits each: CSD LUT constants for index n_lut, valid in the same cycle.
REQ-012 SHALL have port n_lut, output, LOG2N bits: current iteration index driven to the external LUT.
REQ-013 SHALL have ports busy and done, outputs, 1 bit each.
REQ-014 SHALL have ports u_res and v_res, outputs, 2*W bits each: CSD results.
REQ-015 SHALL have port iter_cnt, output, LOG2N+1 bits: number of iterations executed in the last run.

Function
REQ-016 FSM SHALL have states IDLE, RUN and DONE; transitions occur only on edges where enable=1.
REQ-017 IDLE with start=1 SHALL capture mode, format, u_0 and v_0 into internal registers, clear n to 0, and go to RUN.
REQ-018 RUN SHALL, per enabled edge, replace u/v with the step result for index n, then increment n.
REQ-019 RUN SHALL go to DONE on the edge that processes n=N-1.
REQ-020 Latency SHALL be: start accepted at edge k gives done=1 after edge k+N (N enabled edges), and done SHALL last exactly one enabled cycle before DONE returns to IDLE.
REQ-021 Digits SHALL be selected from E, the signed sum of the 4 most significant CSD digit positions of the current u (for d_u) or v (for d_v): d=+1 (01) if E>=2, d=-1 (11) if E<=-2, d=0 (00) otherwise; encoding 10 is never generated.
REQ-022 busy SHALL be 1 in RUN and DONE; start while busy=1 SHALL be ignored, with no effect on state or data.
REQ-023 u_res, v_res and iter_cnt SHALL update only on entry to DONE and hold until the next DONE.
REQ-024 n_lut SHALL equal n in RUN and 0 otherwise.
REQ-025 start and DONE->IDLE on the same edge SHALL NOT accept the start; start is accepted only in IDLE.

Reset
REQ-026 arst=1 SHALL immediately force state IDLE, n=0, busy=0, done=0, u_res=0, v_res=0, iter_cnt=0 and all internal registers to 0.
REQ-027 srst=1 with enable=1 SHALL produce the same values as REQ-026 at the edge, overriding start.
REQ-028 Reset mid-run SHALL abandon the run, with no done pulse and results cleared.

Configuration
REQ-029 With BKM_CONTROL_SEQ_EARLY_TERM_EN defined, RUN SHALL go to DONE after the first edge at which the updated u and v are both all-zero CSD, with iter_cnt equal to the iterations done; without the macro, every run SHALL take exactly N iterations and iter_cnt SHALL equal N.

Structure
REQ-030 Package bkm_pkg SHALL hold the FSM state typedef, the CSD digit codes (D_ZERO=00, D_POS=01, D_NEG=11) and the estimate thresholds (+2/-2).
REQ-031 The datapath SHALL instantiate one existing sub-module, bkm_control_step, combinationally per iteration.

Verification
REQ-032 Reset: assert arst -> all outputs 0 and state IDLE, with no clock edge required.
REQ-033 W=8, N=8, u_0=v_0=0, start at edge k -> done=1 after edge k+8, u_res=v_res=0, and iter_cnt=8 (1 with the macro, after edge k+1).
REQ-034 start pulsed at edges k+2..k+5 of a run -> no effect, exactly one done pulse, and the next start accepted only in IDLE.
REQ-035 enable=0 for 3 cycles mid-run -> done delayed by exactly 3 cycles and results identical to the unstalled run.
REQ-036 arst at edge k+4 of a run -> busy=0 immediately, no done pulse, and u_res=0.
REQ-037 Random u_0/v_0/mode over 1000 runs -> u_res/v_res match an N-fold reference model of bkm_control_step using the REQ-021 digit rule, and no 10 digit code occurs.

Source files
------------

// File: rtl/bkm_control_seq_pkg.sv
// bkm_pkg: shared types and constants for the BKM control sequencer.
//   state_t              : sequencer FSM states (IDLE, RUN, DONE)
//   D_ZERO/D_POS/D_NEG   : 2-bit CSD digit codes (10 is never produced)
//   E_POS_TH/E_NEG_TH    : digit-selection thresholds on the 4-digit estimate
//   digit_val/digit_sel/digit_mul : CSD digit helpers used by the step logic
package bkm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] D_ZERO = 2'b00;
  localparam logic [1:0] D_POS  = 2'b01;
  localparam logic [1:0] D_NEG  = 2'b11;

  localparam logic signed [3:0] E_POS_TH = 4'sd2;
  localparam logic signed [3:0] E_NEG_TH = -4'sd2;

  // Signed value of one CSD digit; the unused code 10 reads as zero.
  function automatic logic signed [3:0] digit_val(input logic [1:0] d);
    case (d)
      D_POS:   return 4'sd1;
      D_NEG:   return -4'sd1;
      default: return 4'sd0;
    endcase
  endfunction

  // Digit choice from the signed estimate of the leading digits.
  function automatic logic [1:0] digit_sel(input logic signed [3:0] e);
    if (e >= E_POS_TH) return D_POS;
    if (e <= E_NEG_TH) return D_NEG;
    return D_ZERO;
  endfunction

  // Product of two CSD digits, result always a legal code.
  function automatic logic [1:0] digit_mul(input logic [1:0] d, input logic [1:0] c);
    logic signed [3:0] p;
    p = digit_val(d) * digit_val(c);
    if (p > 4'sd0) return D_POS;
    if (p < 4'sd0) return D_NEG;
    return D_ZERO;
  endfunction

endpackage

// File: rtl/bkm_control_seq_if.sv
// bkm_control_seq_if: run request / result bus of the BKM sequencer plus the
// external LUT lookup path.
//   master : drives start, mode, format, u_0, v_0 and the LUT data lut_u/lut_v
//   slave  : the sequencer; drives n_lut, busy, done, u_res, v_res, iter_cnt
interface bkm_control_seq_if #(
  parameter int W     = 8,
  parameter int LOG2N = 3
);
  import bkm_pkg::*;

  logic                 start;
  logic                 mode;
  logic [1:0]           format;
  logic [2*W-1:0]       u_0;
  logic [2*W-1:0]       v_0;
  logic [2*W-1:0]       lut_u;
  logic [2*W-1:0]       lut_v;
  logic [LOG2N-1:0]     n_lut;
  logic                 busy;
  logic                 done;
  logic [2*W-1:0]       u_res;
  logic [2*W-1:0]       v_res;
  logic [LOG2N:0]       iter_cnt;

  modport master (
    output start, mode, format, u_0, v_0, lut_u, lut_v,
    input  n_lut, busy, done, u_res, v_res, iter_cnt
  );

  modport slave (
    input  start, mode, format, u_0, v_0, lut_u, lut_v,
    output n_lut, busy, done, u_res, v_res, iter_cnt
  );
endinterface

// File: rtl/bkm_control_seq_step.sv
// bkm_control_step: one combinational BKM iteration on W-digit CSD operands.
//   mode          : 0 = each operand absorbs its own LUT term, 1 = cross-coupled
//   format        : selects which LUT digit position feeds the update
//   u, v          : current CSD operands (2*W bits)
//   lut_u, lut_v  : LUT constants for the current iteration index
//   u_next,v_next : operands shifted up one digit with the new term as LSD
module bkm_control_step
  import bkm_pkg::*;
#(
  parameter int W     = 8,
  parameter int LOG2W = 3
) (
  input  logic           mode,
  input  logic [1:0]     format,
  input  logic [2*W-1:0] u,
  input  logic [2*W-1:0] v,
  input  logic [2*W-1:0] lut_u,
  input  logic [2*W-1:0] lut_v,
  output logic [2*W-1:0] u_next,
  output logic [2*W-1:0] v_next
);

  logic [LOG2W-1:0]  k;
  logic signed [3:0] e_u, e_v;
  logic [1:0]        d_u, d_v, c_u, c_v;

  assign k = LOG2W'(format);

  always_comb begin
    e_u = 4'sd0;
    e_v = 4'sd0;
    // Estimate from the four most significant digit positions only.
    for (int i = W - 4; i < W; i++) begin
      e_u = e_u + digit_val(u[2*i +: 2]);
      e_v = e_v + digit_val(v[2*i +: 2]);
    end
    d_u = digit_sel(e_u);
    d_v = digit_sel(e_v);
    c_u = digit_mul(d_u, lut_u[2*int'(k) +: 2]);
    c_v = digit_mul(d_v, lut_v[2*int'(k) +: 2]);
    u_next = {u[2*W-3:0], mode ? c_v : c_u};
    v_next = {v[2*W-3:0], mode ? c_u : c_v};
  end

endmodule

// File: rtl/bkm_control_seq.sv
// bkm_control_seq: runs N iterations of bkm_control_step on captured CSD
// operands, fetching per-iteration constants from an external LUT.
//   clk    : clock, rising edge
//   arst   : asynchronous active-high reset
//   srst   : synchronous active-high reset, honoured only when enable=1
//   enable : clock enable; all state holds while low
//   bus    : bkm_control_seq_if.slave (start/operands in, LUT index out,
//            busy/done/results out)
// Optional feature: define BKM_CONTROL_SEQ_EARLY_TERM_EN to finish a run as
// soon as both updated operands are all-zero CSD.
module bkm_control_seq
  import bkm_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 8,
  parameter int LOG2W = 3,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             srst,
  input  logic             enable,
  bkm_control_seq_if.slave bus
);

  state_t           state, state_nxt;
  logic [LOG2N-1:0] n;
  logic             mode_r;
  logic [1:0]       fmt_r;
  logic [2*W-1:0]   u_r, v_r, u_step, v_step;
  logic [2*W-1:0]   u_res_r, v_res_r;
  logic [LOG2N:0]   iter_r;
  logic             last;

  bkm_control_step #(.W(W), .LOG2W(LOG2W)) u_step_i (
    .mode   (mode_r),
    .format (fmt_r),
    .u      (u_r),
    .v      (v_r),
    .lut_u  (bus.lut_u),
    .lut_v  (bus.lut_v),
    .u_next (u_step),
    .v_next (v_step)
  );

  always_comb begin
    last = (n == LOG2N'(N - 1));
`ifdef BKM_CONTROL_SEQ_EARLY_TERM_EN
    if ((u_step == '0) && (v_step == '0)) last = 1'b1;
`endif
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst)        state <= IDLE;
    else if (enable) state <= srst ? IDLE : state_nxt;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      n <= '0; mode_r <= 1'b0; fmt_r <= '0; u_r <= '0; v_r <= '0;
      u_res_r <= '0; v_res_r <= '0; iter_r <= '0;
    end else if (enable) begin
      if (srst) begin
        n <= '0; mode_r <= 1'b0; fmt_r <= '0; u_r <= '0; v_r <= '0;
        u_res_r <= '0; v_res_r <= '0; iter_r <= '0;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            mode_r <= bus.mode;
            fmt_r  <= bus.format;
            u_r    <= bus.u_0;
            v_r    <= bus.v_0;
            n      <= '0;
          end
          RUN: begin
            u_r <= u_step;
            v_r <= v_step;
            // Results are published only on the edge that enters DONE.
            if (last) begin
              n       <= '0;
              u_res_r <= u_step;
              v_res_r <= v_step;
              iter_r  <= (LOG2N+1)'(n) + (LOG2N+1)'(1);
            end else begin
              n <= n + LOG2N'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.n_lut    = (state == RUN) ? n : '0;
  assign bus.u_res    = u_res_r;
  assign bus.v_res    = v_res_r;
  assign bus.iter_cnt = iter_r;

endmodule

// File: tb/tb_bkm_control_seq.sv
// Scoreboard bench for bkm_control_seq (W=8, N=8): directed vectors with
// hand-derived results, stall/reset/ignored-start cases, then random runs
// checked against an independent digit-level reference model.
module tb_bkm_control_seq;

  localparam int W = 8, N = 8, LOG2W = 3, LOG2N = 3;
`ifdef BKM_CONTROL_SEQ_EARLY_TERM_EN
  localparam int ZERO_IT = 1;
`else
  localparam int ZERO_IT = N;
`endif

  typedef struct packed {
    logic [15:0] u;
    logic [15:0] v;
    logic [3:0]  it;
  } exp_t;

  logic clk = 1'b0;
  logic arst, srst, enable;
  always #5 clk = ~clk;

  bkm_control_seq_if #(.W(W), .LOG2N(LOG2N)) bus();

  bkm_control_seq #(.W(W), .N(N), .LOG2W(LOG2W), .LOG2N(LOG2N)) dut (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable), .bus(bus.slave)
  );

  logic [15:0] LUT_U [8] = '{16'h0001, 16'h4C35, 16'hF0D5, 16'h3711,
                             16'hC4FD, 16'h0345, 16'h7C01, 16'hDF15};
  logic [15:0] LUT_V [8] = '{16'h000F, 16'h5C43, 16'hD717, 16'h3F0F,
                             16'h4D53, 16'hC0F7, 16'h1473, 16'hF5C3};
  assign bus.lut_u = LUT_U[bus.n_lut];
  assign bus.lut_v = LUT_V[bus.n_lut];

  exp_t sb[$];
  exp_t mon_e;
  int n_tests = 0, n_fail = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic has10(input logic [15:0] x);
    for (int i = 0; i < 8; i++) if (x[2*i +: 2] == 2'b10) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done: got u_res %0h with no run pending", bus.u_res);
      end else begin
        mon_e = sb.pop_front();
        chk("u_res", 32'(bus.u_res), 32'(mon_e.u));
        chk("v_res", 32'(bus.v_res), 32'(mon_e.v));
        chk("iter_cnt", 32'(bus.iter_cnt), 32'(mon_e.it));
        chk("no_10_code", 32'(has10(bus.u_res) | has10(bus.v_res)), 32'd0);
      end
    end
  end

  // Reference model.
  function automatic int dv(input logic [1:0] c);
    return (c == 2'b01) ? 1 : ((c == 2'b11) ? -1 : 0);
  endfunction
  function automatic logic [1:0] de(input int x);
    return (x > 0) ? 2'b01 : ((x < 0) ? 2'b11 : 2'b00);
  endfunction
  function automatic int sel(input logic [15:0] x);
    int e = 0;
    for (int i = 4; i < 8; i++) e += dv(x[2*i +: 2]);
    return (e >= 2) ? 1 : ((e <= -2) ? -1 : 0);
  endfunction
  function automatic exp_t model(input logic m, input logic [1:0] f,
                                 input logic [15:0] u0, input logic [15:0] v0);
    exp_t r;
    logic [15:0] u, v, lu, lv;
    int cu, cv, fi;
    u = u0; v = v0; fi = int'(f); r.it = 4'd0;
    for (int n = 0; n < N; n++) begin
      lu = LUT_U[n]; lv = LUT_V[n];
      cu = sel(u) * dv(lu[2*fi +: 2]);
      cv = sel(v) * dv(lv[2*fi +: 2]);
      u = {u[13:0], de(m ? cv : cu)};
      v = {v[13:0], de(m ? cu : cv)};
      r.it = r.it + 4'd1;
`ifdef BKM_CONTROL_SEQ_EARLY_TERM_EN
      if (u == 16'h0 && v == 16'h0) break;
`endif
    end
    r.u = u; r.v = v;
    return r;
  endfunction

  function automatic logic [15:0] rnd_csd();
    logic [15:0] x;
    for (int i = 0; i < 8; i++)
      case ($urandom_range(0, 2))
        0:       x[2*i +: 2] = 2'b00;
        1:       x[2*i +: 2] = 2'b01;
        default: x[2*i +: 2] = 2'b11;
      endcase
    return x;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one run and wait (bounded) for its done pulse; lat = edges from
  // the accepting edge to the edge that raised done.
  task automatic run_op(input logic m, input logic [1:0] f, input logic [15:0] u0,
                        input logic [15:0] v0, input exp_t e, input int stall_at,
                        output int lat);
    int proc; bit seen; bit stalled;
    sb.push_back(e);
    bus.start = 1'b1; bus.mode = m; bus.format = f; bus.u_0 = u0; bus.v_0 = v0;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    lat = 0; proc = 0; seen = 0; stalled = 0;
    while (!seen && lat < 64) begin
      if (stall_at > 0 && proc == stall_at && !stalled) begin
        enable = 1'b0; repeat (3) tick(); enable = 1'b1; lat += 3; stalled = 1;
      end
      tick(); lat++; proc++;
      if (bus.done === 1'b1) seen = 1;
      else chk("n_lut_run", 32'(bus.n_lut), 32'(proc));
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done within %0d edges, required one", lat);
    end
    tick();
  endtask

  initial begin
    int lat, d0;
    exp_t e;
    logic m; logic [1:0] f; logic [15:0] u0, v0;
    #5_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0;
    exp_t e;
    logic m; logic [1:0] f; logic [15:0] u0, v0;
    arst = 1'b1; srst = 1'b0; enable = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0; bus.format = 2'd0; bus.u_0 = '0; bus.v_0 = '0;
    #2;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_u_res", 32'(bus.u_res), 32'd0);
    chk("rst_v_res", 32'(bus.v_res), 32'd0);
    chk("rst_iter", 32'(bus.iter_cnt), 32'd0);
    chk("rst_n_lut", 32'(bus.n_lut), 32'd0);
    @(negedge clk); arst = 1'b0;
    tick();

    // Zero operands.
    e = '{u: 16'h0, v: 16'h0, it: 4'(ZERO_IT)};
    run_op(1'b0, 2'd0, 16'h0, 16'h0, e, 0, lat);
    chk("lat_zero", 32'(lat), 32'(ZERO_IT));

    // All +1 digits, own-term mode: u stays all +1, v stays 0.
    e = '{u: 16'h5555, v: 16'h0, it: 4'd8};
    run_op(1'b0, 2'd0, 16'h5555, 16'h0, e, 0, lat);
    chk("lat_mode0", 32'(lat), 32'd8);

    // Cross-coupled: v collects seven +1 terms, u gets two -1 terms at the end.
    e = '{u: 16'h000F, v: 16'h5554, it: 4'd8};
    run_op(1'b1, 2'd0, 16'h5555, 16'h0, e, 0, lat);
    chk("lat_mode1", 32'(lat), 32'd8);

    // Three-cycle enable stall mid-run.
    e = '{u: 16'h5555, v: 16'h0, it: 4'd8};
    run_op(1'b0, 2'd0, 16'h5555, 16'h0, e, 3, lat);
    chk("lat_stall", 32'(lat), 32'd11);

    // start pulses while busy and in DONE are ignored.
    d0 = done_cnt;
    sb.push_back('{u: 16'h000F, v: 16'h5554, it: 4'd8});
    bus.start = 1'b1; bus.mode = 1'b1; bus.format = 2'd0; bus.u_0 = 16'h5555; bus.v_0 = 16'h0;
    tick();
    bus.start = 1'b0;
    tick();
    for (int i = 2; i <= 5; i++) begin
      bus.start = 1'b1; bus.mode = 1'b0; bus.u_0 = 16'hFFFF; bus.v_0 = 16'h5555;
      tick();
    end
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 32) begin tick(); lat++; end
    chk("busy_ign_done", 32'(bus.done), 32'd1);
    bus.start = 1'b1; bus.u_0 = 16'h0; bus.v_0 = 16'h0;
    tick();
    bus.start = 1'b0;
    chk("start_in_done_ignored", 32'(bus.busy), 32'd0);
    repeat (12) tick();
    chk("one_done_pulse", 32'(done_cnt - d0), 32'd1);

    // Asynchronous reset mid-run.
    d0 = done_cnt;
    bus.start = 1'b1; bus.mode = 1'b0; bus.u_0 = 16'h5555; bus.v_0 = 16'h0;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    @(posedge clk); #2;
    arst = 1'b1; #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_u_res", 32'(bus.u_res), 32'd0);
    chk("arst_v_res", 32'(bus.v_res), 32'd0);
    chk("arst_iter", 32'(bus.iter_cnt), 32'd0);
    @(negedge clk); arst = 1'b0;
    repeat (12) tick();
    chk("arst_no_done", 32'(done_cnt - d0), 32'd0);

    // Synchronous reset overrides start in IDLE and clears results.
    e = '{u: 16'h5555, v: 16'h0, it: 4'd8};
    run_op(1'b0, 2'd0, 16'h5555, 16'h0, e, 0, lat);
    srst = 1'b1; bus.start = 1'b1;
    tick();
    srst = 1'b0; bus.start = 1'b0;
    chk("srst_busy", 32'(bus.busy), 32'd0);
    chk("srst_u_res", 32'(bus.u_res), 32'd0);
    chk("srst_iter", 32'(bus.iter_cnt), 32'd0);

    // Synchronous reset mid-run.
    d0 = done_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("srst_run_busy", 32'(bus.busy), 32'd0);
    repeat (12) tick();
    chk("srst_no_done", 32'(done_cnt - d0), 32'd0);

    // Random runs against the reference model.
    for (int r = 0; r < 1000; r++) begin
      m = 1'($urandom_range(0, 1));
      f = 2'($urandom_range(0, 3));
      u0 = rnd_csd();
      v0 = rnd_csd();
      e = model(m, f, u0, v0);
      run_op(m, f, u0, v0, e, 0, lat);
    end

    repeat (2) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
